// File: rtl/dmem_port_arbiter.sv
// Two-requester (CPU, DMA) arbiter for the single data-memory/IO port; one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of fixed CPU priority.
module dmem_port_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [3:0] LAT     = 4'(RD_LAT);

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_we;
  logic              r_refused;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_any_req;
  logic              w_grant_d;

  assign w_any_req = c_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Resets to "DMA served last" so the first tie goes to the CPU.
  logic r_last_d;

  assign w_grant_d = d_req & (~c_req | ~r_last_d);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b1;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = d_req & ~c_req;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_refused <= 1'b0;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner   <= w_grant_d;
            r_we      <= w_grant_d ? d_we : c_we;
            r_addr    <= w_grant_d ? d_addr : c_addr;
            r_wdata   <= w_grant_d ? d_wdata : c_wdata;
            r_refused <= w_grant_d & d_addr[7];
            r_cnt     <= 4'd1;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == LAT) begin
            if (!r_we && !r_refused) begin
              r_rdata <= mem_rdata;
            end
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_ACK: begin
          r_cnt   <= 4'd0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Decoded straight from state so an async reset removes the strobe and acks at once.
  assign mem_we    = (r_state == ST_BUSY) && (r_cnt == 4'd1) && r_we && !r_refused;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;
  assign c_ack     = (r_state == ST_ACK) && !r_owner;
  assign d_ack     = (r_state == ST_ACK) && r_owner;
  assign d_err     = (r_state == ST_ACK) && r_owner && r_refused;
  assign c_stall   = c_req & ~c_ack;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, hand-written corner sequences, and a randomized
// run against a transaction-level reference model. Two instances: RD_LAT=1 and RD_LAT=3.
module tb_dmem_port_arbiter;

  localparam int LAT1 = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;

  logic        c_ack_1, c_stall_1, d_ack_1, d_err_1, mem_we_1;
  logic [31:0] rdata_1, mem_addr_1, mem_wdata_1;
  logic        c_ack_3, c_stall_3, d_ack_3, d_err_3, mem_we_3;
  logic [31:0] rdata_3, mem_addr_3, mem_wdata_3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack_1), .c_stall(c_stall_1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_1), .d_err(d_err_1), .rdata(rdata_1),
    .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata)
  );

  dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack_3), .c_stall(c_stall_3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_3), .d_err(d_err_3), .rdata(rdata_3),
    .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_we_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // One isolated transaction on the RD_LAT=1 instance.
  task automatic run_txn(input int idx, input vec_t v);
    int          ack_cyc, we_cnt, we_cyc, other_ack;
    logic        err;
    logic [31:0] rd, we_addr, we_data;
    ack_cyc = -1; we_cnt = 0; we_cyc = -1; other_ack = 0;
    err = 1'bx; rd = 'x; we_addr = 'x; we_data = 'x;
    step();
    mem_rdata = v.mrd;
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      c_req = 1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
    end
    for (int cyc = 0; cyc < 12 && ack_cyc < 0; cyc++) begin
      if (cyc > 0) step();
      @(negedge clock);
      if (mem_we_1) begin
        we_cnt++; we_cyc = cyc; we_addr = mem_addr_1; we_data = mem_wdata_1;
      end
      if (!v.is_d) check($sformatf("v%0d c_stall cyc%0d", idx, cyc), c_stall_1, (cyc != LAT1 + 1));
      if (v.is_d ? c_ack_1 : d_ack_1) other_ack++;
      if (v.is_d ? d_ack_1 : c_ack_1) begin
        ack_cyc = cyc; err = d_err_1; rd = rdata_1;
      end
    end
    step();
    c_req = 0; d_req = 0;
    check($sformatf("v%0d ack_cycle", idx), 32'(ack_cyc), 32'(LAT1 + 1));
    check($sformatf("v%0d other_ack", idx), 32'(other_ack), 0);
    check($sformatf("v%0d mem_we_count", idx), 32'(we_cnt), 32'(v.exp_we_cnt));
    if (v.exp_we_cnt > 0) begin
      check($sformatf("v%0d mem_we_cycle", idx), 32'(we_cyc), 1);
      check($sformatf("v%0d mem_addr", idx), we_addr, v.addr);
      check($sformatf("v%0d mem_wdata", idx), we_data, v.wdata);
    end
    check($sformatf("v%0d d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
    check($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
  endtask

  // Reference model state (transaction level).
  int          m_start, m_ack, m_next_free;
  logic        m_owner_d, m_we, m_ref, m_last_d;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        c_pend, d_pend, c_clear, d_clear;

  initial begin
    int          grants[$];
    int          acks[$];
    int          exp_g[4];
    int          n_ack3;
    logic        eb_c, eb_d, ew;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 32'h84, 32'h5,  32'h11111111, 32'hDEADBEEF, 1'b0, 1};
    vecs[2] = '{1'b1, 1'b1, 32'h80, 32'h7,  32'h22222222, 32'hDEADBEEF, 1'b1, 0};
    vecs[3] = '{1'b1, 1'b1, 32'h04, 32'h9,  32'h33333333, 32'hDEADBEEF, 1'b0, 1};
    vecs[4] = '{1'b1, 1'b0, 32'h90, 32'h0,  32'h12345678, 32'hDEADBEEF, 1'b1, 0};
    vecs[5] = '{1'b0, 1'b0, 32'h88, 32'h0,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 0};
    vecs[6] = '{1'b1, 1'b0, 32'h20, 32'h0,  32'h0BADF00D, 32'h0BADF00D, 1'b0, 0};

    // Reset state
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst c_ack", c_ack_1, 0);
    check("rst d_ack", d_ack_1, 0);
    check("rst d_err", d_err_1, 0);
    check("rst rdata", rdata_1, 0);
    check("rst mem_we", mem_we_1, 0);
    check("rst mem_addr", mem_addr_1, 0);
    check("rst mem_wdata", mem_wdata_1, 0);
    check("rst3 mem_addr", mem_addr_3, 0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

    // Both requesters held high for four transactions.
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    do_reset();
    step();
    c_req = 1; c_we = 0; c_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    mem_rdata = 32'h55AA55AA;
    for (int cyc = 0; cyc < 30 && grants.size() < 4; cyc++) begin
      if (cyc > 0) step();
      @(negedge clock);
      if (c_ack_1) grants.push_back(0);
      if (d_ack_1) grants.push_back(1);
    end
    step();
    clear_inputs();
    check("tie grant_count", 32'(grants.size()), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check($sformatf("tie grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));

    // Back-to-back CPU reads: acks at cycles 2, 5, 8.
    do_reset();
    step();
    c_req = 1; c_we = 0; c_addr = 32'h40; mem_rdata = 32'h01020304;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc > 0) step();
      @(negedge clock);
      if (c_ack_1) acks.push_back(cyc);
    end
    step();
    clear_inputs();
    check("b2b ack_count", 32'(acks.size()), 3);
    for (int i = 0; i < 3 && i < acks.size(); i++)
      check($sformatf("b2b ack%0d", i), 32'(acks[i]), 32'(3 * i + 2));

    // RD_LAT=3: reset in the first BUSY cycle drops mem_we asynchronously.
    do_reset();
    step();
    c_req = 1; c_we = 1; c_addr = 32'h08; c_wdata = 32'hA5;
    step();
    @(negedge clock);
    check("lat3 mem_we busy1", mem_we_3, 1);
    #1 reset = 1'b1;
    #1;
    check("lat3 mem_we async drop", mem_we_3, 0);
    step();
    c_req = 0;
    reset = 1'b0;

    // RD_LAT=3: reset in the second BUSY cycle, then no ack after release.
    step();
    c_req = 1; c_we = 0; c_addr = 32'h0C; mem_rdata = 32'h77777777;
    step();
    step();
    reset = 1'b1;
    #1;
    check("lat3 c_ack in reset", c_ack_3, 0);
    check("lat3 c_stall in reset", c_stall_3, 1);
    check("lat3 rdata in reset", rdata_3, 0);
    check("lat3 mem_addr in reset", mem_addr_3, 0);
    step();
    c_req = 0;
    reset = 1'b0;
    n_ack3 = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clock);
      if (c_ack_3 || d_ack_3) n_ack3++;
      step();
    end
    check("lat3 ack after release", 32'(n_ack3), 0);
    check("lat3 rdata after release", rdata_3, 0);

    // Randomized run on RD_LAT=1 against the transaction-level model.
    do_reset();
    m_start = -100; m_ack = -100; m_next_free = 0;
    m_owner_d = 0; m_we = 0; m_ref = 0; m_last_d = 1;
    m_addr = 0; m_wdata = 0; m_rdata = 0;
    c_pend = 0; d_pend = 0; c_clear = 0; d_clear = 0;
    for (int k = 0; k < 1500; k++) begin
      step();
      if (c_clear) begin c_pend = 0; c_clear = 0; end
      if (d_clear) begin d_pend = 0; d_clear = 0; end
      if (!c_pend && $urandom_range(0, 2) == 0) begin
        c_pend = 1; c_we = 1'($urandom);
        c_addr = $urandom & 32'hFF; c_wdata = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we = 1'($urandom);
        d_addr = $urandom & 32'hFF; d_wdata = $urandom;
      end
      c_req = c_pend;
      d_req = d_pend;
      mem_rdata = $urandom;
      @(negedge clock);
      eb_c = (k == m_ack) && !m_owner_d;
      eb_d = (k == m_ack) && m_owner_d;
      ew   = (k == m_start + 1) && m_we && !m_ref;
      check("rnd c_ack", c_ack_1, eb_c);
      check("rnd d_ack", d_ack_1, eb_d);
      check("rnd d_err", d_err_1, eb_d && m_ref);
      check("rnd c_stall", c_stall_1, c_req && !eb_c);
      check("rnd mem_we", mem_we_1, ew);
      check("rnd mem_addr", mem_addr_1, m_addr);
      check("rnd mem_wdata", mem_wdata_1, m_wdata);
      check("rnd rdata", rdata_1, m_rdata);
      if (eb_c) c_clear = 1;
      if (eb_d) d_clear = 1;
      if (k == m_start + LAT1 && !m_we && !m_ref) m_rdata = mem_rdata;
      if (k >= m_next_free && (c_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
        m_owner_d = d_req && (!c_req || !m_last_d);
`else
        m_owner_d = d_req && !c_req;
`endif
        m_last_d    = m_owner_d;
        m_we        = m_owner_d ? d_we : c_we;
        m_addr      = m_owner_d ? d_addr : c_addr;
        m_wdata     = m_owner_d ? d_wdata : c_wdata;
        m_ref       = m_owner_d && d_addr[7];
        m_start     = k;
        m_ack       = k + LAT1 + 1;
        m_next_free = k + LAT1 + 2;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
